barcode_reader: RTL and testbench

Decodes the serial station-ID barcode stream on the robot's BC input pin.
It self-calibrates its timing from the start pulse and shifts in 8 data bits MSB first.
A good ID (upper two bits 00) is latched and flagged to the command/control logic, which uses it for station matching and stopping.
It is the stage directly downstream of the barcode stimulus driven on BC at the top level.

---
 rtl/barcode_pkg.sv | 6 +
 rtl/barcode_reader_sync.sv | 21 ++
 rtl/barcode_reader.sv | 77 +++++++
 tb/tb_barcode_reader.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/barcode_pkg.sv
// barcode_pkg: shared types and constants for the station-ID barcode reader
package barcode_pkg;
  typedef enum logic [2:0] {IDLE, MEAS, WAIT_FALL, SAMP, CHK} bc_state_t;
  localparam int ID_BITS = 8;
  localparam logic [7:0] VALID_MASK = 8'hC0;
endpackage

// File: rtl/barcode_reader_sync.sv
// bc_sync: two-flop synchroniser plus history flop giving registered-level edge strobes
module bc_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic sync,
  output logic fall,
  output logic rise
);
  logic meta, prev;
  always_ff @(posedge clk) begin
    if (!rst_n) {meta, sync, prev} <= 3'b111;
    else begin
      meta <= pin;
      sync <= meta;
      prev <= sync;
    end
  end
  assign fall = prev & ~sync;
  assign rise = ~prev & sync;
endmodule

// File: rtl/barcode_reader.sv
// barcode_reader: self-calibrating serial station-ID decoder with sticky valid flag
module barcode_reader #(
  parameter int TIMER_W = 22,
  parameter int ID_BITS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               BC,
  input  logic               clr_ID_vld,
  output logic [ID_BITS-1:0] ID,
  output logic               ID_vld
);
  import barcode_pkg::*;
  localparam int BCW = $clog2(ID_BITS) + 1;
  logic sync, fall, rise;
  bc_state_t state, state_nxt;
  logic [TIMER_W-1:0] cnt, cnt_nxt, half;
  logic [ID_BITS-1:0] shreg;
  logic [BCW-1:0] bit_cnt;
  logic cnt_max, samp_hit, last_bit, ld_half, ld_id;
  bc_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .pin  (BC),
    .sync (sync),
    .fall (fall),
    .rise (rise)
  );
  assign cnt_max  = &cnt;
  assign samp_hit = (state == SAMP) && (cnt == half);
  assign last_bit = bit_cnt == BCW'(ID_BITS - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = fall ? MEAS : IDLE;
      MEAS:      state_nxt = rise ? WAIT_FALL : cnt_max ? IDLE : MEAS;
      WAIT_FALL: state_nxt = fall ? SAMP : cnt_max ? IDLE : WAIT_FALL;
      SAMP:      state_nxt = !samp_hit ? SAMP : last_bit ? CHK : WAIT_FALL;
      CHK:       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end
  // Counter restarts at 1 on a fall because the fall cycle itself is the first low cycle
  always_comb begin
    ld_half = (state == MEAS) && rise;
    ld_id   = (state == CHK) && ~|(shreg & VALID_MASK);
    cnt_nxt = (fall && (state == IDLE || state == WAIT_FALL)) ? TIMER_W'(1) :
              (ld_half || (samp_hit && !last_bit)) ? '0 :
              (state == IDLE || state == CHK) ? cnt : cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      half    <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      ID      <= '0;
      ID_vld  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (ld_half) begin
        half    <= cnt;
        bit_cnt <= '0;
      end
      if (samp_hit) begin
        shreg   <= {shreg[ID_BITS-2:0], sync};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (ld_id) ID <= shreg;
      ID_vld <= ld_id | (ID_vld & ~clr_ID_vld);
    end
  end
endmodule

// File: tb/tb_barcode_reader.sv
// tb_barcode_reader: scoreboard-driven bench; narrow timer keeps long-pulse cases short
module tb_barcode_reader;
  localparam int TW = 12;
  logic clk = 0, rst_n = 0, BC = 1, clr_ID_vld = 0;
  logic [7:0] ID;
  logic ID_vld;
  int errors = 0, checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;
  int lat;

  barcode_reader #(.TIMER_W(TW), .ID_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .BC        (BC),
    .clr_ID_vld(clr_ID_vld),
    .ID        (ID),
    .ID_vld    (ID_vld)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_ID_vld = 1;
    @(negedge clk);
    clr_ID_vld = 0;
    @(negedge clk);
  endtask

  task automatic send_start(input int h);
    BC = 0;
    repeat (h) @(negedge clk);
    BC = 1;
    repeat (h) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int h);
    int lo;
    lo = b ? h / 2 : h + h / 2;
    BC = 0;
    repeat (lo) @(negedge clk);
    BC = 1;
    repeat (2 * h - lo) @(negedge clk);
  endtask

  // Last bit is driven cycle by cycle so the valid latency after its fall can be measured
  task automatic send_frame(input logic [7:0] id, input int h, input int clr_at, output int l);
    int lo, len;
    if ((id & 8'hC0) == 8'h00) exp_q.push_back(id);
    l = 0;
    send_start(h);
    for (int i = 7; i > 0; i--) send_bit(id[i], h);
    lo = id[0] ? h / 2 : h + h / 2;
    len = (2 * h > h + 6) ? 2 * h : h + 6;
    BC = 0;
    for (int n = 1; n <= len; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == lo) BC = 1;
      clr_ID_vld = (n == clr_at);
      if (ID_vld && l == 0) l = n;
    end
    clr_ID_vld = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle(3);
    checks++; if (ID !== 8'h00) begin errors++; $display("FAIL reset_id: got %h want 00", ID); end
    checks++; if (ID_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", ID_vld); end
    rst_n = 1;
    idle(5);
  endtask

  task automatic test_decode();
    send_frame(8'h2A, 261, 0, lat);
    e = exp_q.pop_front();
    checks++; if (ID !== e) begin errors++; $display("FAIL decode_id: got %h want %h", ID, e); end
    checks++; if (ID_vld !== 1'b1) begin errors++; $display("FAIL decode_vld: got %b want 1", ID_vld); end
    checks++; if (lat !== 265) begin errors++; $display("FAIL decode_latency: got %0d want 265", lat); end
    idle(50);
    checks++; if (ID_vld !== 1'b1) begin errors++; $display("FAIL decode_hold: got %b want 1", ID_vld); end
    pulse_clr();
    checks++; if (ID_vld !== 1'b0) begin errors++; $display("FAIL decode_clr: got %b want 0", ID_vld); end
  endtask

  task automatic test_invalid();
    send_frame(8'h15, 16, 0, lat);
    e = exp_q.pop_front();
    checks++; if (ID !== e) begin errors++; $display("FAIL good_id: got %h want %h", ID, e); end
    pulse_clr();
    send_frame(8'hC5, 16, 0, lat);
    idle(10);
    checks++; if (ID !== e) begin errors++; $display("FAIL bad_id_kept: got %h want %h", ID, e); end
    checks++; if (ID_vld !== 1'b0) begin errors++; $display("FAIL bad_vld: got %b want 0", ID_vld); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bad_queue: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_clr_race();
    send_frame(8'h3F, 8, 11, lat);
    e = exp_q.pop_front();
    checks++; if (ID !== e) begin errors++; $display("FAIL race_id: got %h want %h", ID, e); end
    checks++; if (ID_vld !== 1'b1) begin errors++; $display("FAIL race_vld: got %b want 1", ID_vld); end
    checks++; if (lat !== 12) begin errors++; $display("FAIL race_latency: got %0d want 12", lat); end
    pulse_clr();
    checks++; if (ID_vld !== 1'b0) begin errors++; $display("FAIL race_clr: got %b want 0", ID_vld); end
  endtask

  task automatic test_reset_midframe();
    send_start(4);
    for (int i = 7; i > 3; i--) send_bit(e[i] ^ e[i] ^ (8'h21 >> i) & 1'b1, 4);
    rst_n = 0;
    @(negedge clk);
    checks++; if (ID !== 8'h00) begin errors++; $display("FAIL midrst_id: got %h want 00", ID); end
    checks++; if (ID_vld !== 1'b0) begin errors++; $display("FAIL midrst_vld: got %b want 0", ID_vld); end
    rst_n = 1;
    idle(10);
    send_frame(8'h21, 4, 0, lat);
    e = exp_q.pop_front();
    checks++; if (ID !== e) begin errors++; $display("FAIL resend_id: got %h want %h", ID, e); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL resend_latency: got %0d want 8", lat); end
  endtask

  task automatic test_back_to_back();
    pulse_clr();
    send_frame(8'h01, 2, 0, lat);
    e = exp_q.pop_front();
    checks++; if (ID !== e) begin errors++; $display("FAIL b2b_first_id: got %h want %h", ID, e); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL b2b_first_latency: got %0d want 6", lat); end
    send_frame(8'h3E, 1000, 0, lat);
    e = exp_q.pop_front();
    checks++; if (ID !== e) begin errors++; $display("FAIL b2b_second_id: got %h want %h", ID, e); end
    checks++; if (ID_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld: got %b want 1", ID_vld); end
  endtask

  task automatic test_timeout();
    pulse_clr();
    BC = 0;
    idle((1 << TW) + 20);
    BC = 1;
    idle(10);
    checks++; if (ID !== e) begin errors++; $display("FAIL stuck_id: got %h want %h", ID, e); end
    checks++; if (ID_vld !== 1'b0) begin errors++; $display("FAIL stuck_vld: got %b want 0", ID_vld); end
    send_frame(8'h12, 5, 0, lat);
    e = exp_q.pop_front();
    checks++; if (ID !== e) begin errors++; $display("FAIL after_stuck_id: got %h want %h", ID, e); end
    checks++; if (ID_vld !== 1'b1) begin errors++; $display("FAIL after_stuck_vld: got %b want 1", ID_vld); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL after_stuck_latency: got %0d want 9", lat); end
  endtask

  initial begin
    e = 8'h00;
    test_reset();
    test_decode();
    test_invalid();
    test_clr_race();
    test_reset_midframe();
    test_back_to_back();
    test_timeout();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drained: got %0d want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
